// File: rtl/write_back_unit.sv
`default_nettype none
// ============================================================================
// write_back_unit : RISC-V write-back stage (ALU/load/link select, retire count)
// Rev 1.0
// ============================================================================
module write_back_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_hold,
  input  logic             i_flush,
  input  logic [31:0]      i_instr,
  input  logic [XLEN-1:0]  i_result,
  input  logic [XLEN-1:0]  i_load_data,
  input  logic [XLEN-1:0]  i_pc_plus4,
  output logic             o_wr_enable,
  output logic [4:0]       o_wr_address,
  output logic [XLEN-1:0]  o_wrdata,
  output logic             o_retire,
  output logic             o_misaligned,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instret
);

  localparam logic [6:0] c_op_reg   = 7'b0110011;
  localparam logic [6:0] c_op_imm   = 7'b0010011;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_load  = 7'b0000011;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic [2:0]      w_off;
  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_load_val;
  logic [XLEN-1:0] w_sel_data;
  logic            w_has_wr;
  logic            w_is_load;
  logic            w_ill;
  logic            w_mis;
  logic            w_accept;
  logic            w_unused_instr;

  assign w_opcode       = i_instr[6:0];
  assign w_rd           = i_instr[11:7];
  assign w_funct3       = i_instr[14:12];
  assign w_unused_instr = ^i_instr[31:15];

  assign o_ready  = !i_rst && !i_hold;
  assign w_accept = i_valid && o_ready;

  // On RV32 the offset's top bit is forced to 0 so the word is addressed by [1:0] only.
  assign w_off   = (XLEN == 64) ? i_result[2:0] : {1'b0, i_result[1:0]};
  assign w_shamt = {w_off, 3'b000};
  assign w_shift = i_load_data >> w_shamt;

  always_comb begin
    w_load_val = '0;
    w_ill      = 1'b0;
    w_mis      = 1'b0;
    case (w_funct3)
      3'b000: w_load_val = XLEN'($signed(w_shift[7:0]));
      3'b100: w_load_val = XLEN'(w_shift[7:0]);
      3'b001: begin
        w_load_val = XLEN'($signed(w_shift[15:0]));
        w_mis      = w_off[0];
      end
      3'b101: begin
        w_load_val = XLEN'(w_shift[15:0]);
        w_mis      = w_off[0];
      end
      3'b010: begin
        w_load_val = XLEN'($signed(w_shift[31:0]));
        w_mis      = (w_off[1:0] != 2'b00);
      end
      3'b110: begin
        if (XLEN == 64) begin
          w_load_val = XLEN'(w_shift[31:0]);
          w_mis      = (w_off[1:0] != 2'b00);
        end else begin
          w_ill = 1'b1;
        end
      end
      3'b011: begin
        if (XLEN == 64) begin
          w_load_val = w_shift;
          w_mis      = (w_off != 3'b000);
        end else begin
          w_ill = 1'b1;
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_sel_data = '0;
    w_has_wr   = 1'b0;
    w_is_load  = 1'b0;
    case (w_opcode)
      c_op_reg, c_op_imm, c_op_lui, c_op_auipc: begin
        w_sel_data = i_result;
        w_has_wr   = 1'b1;
      end
      c_op_jal, c_op_jalr: begin
        w_sel_data = i_pc_plus4;
        w_has_wr   = 1'b1;
      end
      c_op_load: begin
        w_is_load  = 1'b1;
        w_sel_data = w_load_val;
        w_has_wr   = !w_ill && !w_mis;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_enable  <= 1'b0;
      o_wr_address <= '0;
      o_wrdata     <= '0;
      o_retire     <= 1'b0;
      o_misaligned <= 1'b0;
      o_illegal    <= 1'b0;
      o_instret    <= '0;
    end else begin
      o_wr_enable  <= 1'b0;
      o_wr_address <= '0;
      o_wrdata     <= '0;
      o_retire     <= 1'b0;
      o_misaligned <= 1'b0;
      o_illegal    <= 1'b0;
      if (w_accept && !i_flush) begin
        // A faulting load reports exactly one flag and never retires.
        if (w_is_load && w_ill) begin
          o_illegal <= 1'b1;
        end else if (w_is_load && w_mis) begin
          o_misaligned <= 1'b1;
        end else begin
          o_retire  <= 1'b1;
          o_instret <= o_instret + 1'b1;
          if (w_has_wr && (w_rd != 5'd0)) begin
            o_wr_enable  <= 1'b1;
            o_wr_address <= w_rd;
            o_wrdata     <= w_sel_data;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
